// File: rtl/axi_interface_pkg.sv
// Shared AXI-Lite types: response codes and the endpoint FSM state encodings.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package axi_interface_pkg;

   typedef enum logic [1:0] {
      AXI_RESP_OKAY   = 2'b00,
      AXI_RESP_EXOKAY = 2'b01,
      AXI_RESP_SLVERR = 2'b10,
      AXI_RESP_DECERR = 2'b11
   } axi_response_t;

   localparam axi_response_t AXI_OKAY   = AXI_RESP_OKAY;
   localparam axi_response_t AXI_SLVERR = AXI_RESP_SLVERR;

   typedef enum logic [1:0] {
      W_IDLE,
      W_COLLECT,
      W_ACCESS,
      W_RESPONSE
   } endpoint_write_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_ACCESS,
      R_RESPONSE
   } endpoint_read_state_t;

   // Inclusive unsigned window test used by the address decoders.
   function automatic logic in_window(input logic [31:0] addr,
                                      input logic [31:0] low,
                                      input logic [31:0] high);
      return (addr >= low) && (addr <= high);
   endfunction

endpackage

// File: rtl/axi_interface.sv
// AXI-Lite write (AW/W/B) and read (AR/R) channel bundles between router and endpoint.
// Latency: wires only.
// Backpressure: standard valid/ready on every channel.
interface axi_write_interface;
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;

   modport slave  (input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
                   output awready, wready, bvalid, bresp);
   modport master (output awvalid, awaddr, wvalid, wdata, wstrb, bready,
                   input  awready, wready, bvalid, bresp);
endinterface

interface axi_read_interface;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;

   modport slave  (input  arvalid, araddr, rready,
                   output arready, rvalid, rdata, rresp);
   modport master (output arvalid, araddr, rready,
                   input  arready, rvalid, rdata, rresp);
endinterface

// File: rtl/axi_endpoint_timer.sv
// Peripheral response watchdog; only compiled when AXI_ENDPOINT_TIMEOUT_EN is defined.
// Latency: expired is combinational, high in the TIMEOUT_CYCLES-th enabled cycle after clear.
// Backpressure: none; counter saturates at the limit until cleared.
`ifdef AXI_ENDPOINT_TIMEOUT_EN
module axi_endpoint_timer #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   // Count enabled cycles since the last clear, holding at the limit.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i || clear) begin
         count <= '0;
      end else if (enable && (count != LAST)) begin
         count <= count + CW'(1);
      end
   end

   assign expired = enable && (count == LAST);

endmodule
`endif

// File: rtl/axi_slave_endpoint.sv
// AXI-Lite endpoint: window decode, AW/W/B and AR/R handshakes, request/done peripheral access.
// Latency: request one cycle after the address(+data) handshake; B/R valid one cycle after done.
// Backpressure: one outstanding write and one outstanding read; ready low outside IDLE/COLLECT.
// Optional peripheral timeout is enabled by defining AXI_ENDPOINT_TIMEOUT_EN.
module axi_slave_endpoint
   import axi_interface_pkg::*;
#(
   parameter logic [31:0] LOW_ADDRESS    = 32'h0000_0000,
   parameter logic [31:0] HIGH_ADDRESS   = 32'h0000_0FFF,
   parameter int          TIMEOUT_CYCLES = 256
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   axi_write_interface.slave axi_write_channel,
   axi_read_interface.slave  axi_read_channel,
   output logic              write_match_o,
   output logic              read_match_o,
   output logic              write_busy_o,
   output logic              read_busy_o,
   input  logic              write_bus_taken_i,
   input  logic              read_bus_taken_i,
   output logic [31:0]       write_address_o,
   output logic [31:0]       write_data_o,
   output logic [3:0]        write_strobe_o,
   output logic              write_request_o,
   input  logic              write_done_i,
   input  logic              write_error_i,
   output logic [31:0]       read_address_o,
   output logic              read_request_o,
   input  logic [31:0]       read_data_i,
   input  logic              read_done_i,
   input  logic              read_error_i
);

   endpoint_write_state_t write_state, write_state_next;
   endpoint_read_state_t  read_state, read_state_next;

   logic          aw_captured, w_captured;
   logic          write_open, aw_ready, w_ready, aw_hs, w_hs;
   logic          write_enter_access, write_timeout;
   axi_response_t bresp_q;

   logic          ar_ready, ar_hs, read_enter_access, read_timeout;
   axi_response_t rresp_q;
   logic [31:0]   rdata_q;

   // ---------------- write path ----------------
   assign write_match_o = axi_write_channel.awvalid &&
                          in_window(axi_write_channel.awaddr, LOW_ADDRESS, HIGH_ADDRESS);
   assign write_open    = (write_state == W_IDLE) || (write_state == W_COLLECT);
   assign aw_ready      = write_open && !aw_captured && write_match_o && !write_bus_taken_i;
   // W is only taken alongside or after our own AW, never ahead of it.
   assign w_ready       = write_open && !w_captured && (aw_captured || write_match_o) &&
                          !write_bus_taken_i;
   assign aw_hs         = aw_ready && axi_write_channel.awvalid;
   assign w_hs          = w_ready && axi_write_channel.wvalid;
   assign write_enter_access = write_open && (write_state_next == W_ACCESS);

   assign axi_write_channel.awready = aw_ready;
   assign axi_write_channel.wready  = w_ready;
   assign axi_write_channel.bvalid  = (write_state == W_RESPONSE);
   assign axi_write_channel.bresp   = bresp_q;
   assign write_request_o           = (write_state == W_ACCESS);
   assign write_busy_o              = (write_state != W_IDLE);

   // Write FSM next-state: collect AW and W in any order allowed, then access, then respond.
   always_comb begin
      write_state_next = write_state;
      case (write_state)
         W_IDLE, W_COLLECT: begin
            if ((aw_captured || aw_hs) && (w_captured || w_hs)) begin
               write_state_next = W_ACCESS;
            end else if (aw_hs || w_hs) begin
               write_state_next = W_COLLECT;
            end
         end
         W_ACCESS: begin
            if (write_done_i || write_timeout) begin
               write_state_next = W_RESPONSE;
            end
         end
         W_RESPONSE: begin
            if (axi_write_channel.bready) begin
               write_state_next = W_IDLE;
            end
         end
         default: write_state_next = W_IDLE;
      endcase
   end

   // Write state, capture flags, captured AW/W payload and the latched B response.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         write_state     <= W_IDLE;
         aw_captured     <= 1'b0;
         w_captured      <= 1'b0;
         write_address_o <= '0;
         write_data_o    <= '0;
         write_strobe_o  <= '0;
         bresp_q         <= AXI_OKAY;
      end else begin
         write_state <= write_state_next;
         if (write_enter_access) begin
            aw_captured <= 1'b0;
            w_captured  <= 1'b0;
         end else begin
            if (aw_hs) aw_captured <= 1'b1;
            if (w_hs)  w_captured  <= 1'b1;
         end
         if (aw_hs) begin
            write_address_o <= axi_write_channel.awaddr - LOW_ADDRESS;
         end
         if (w_hs) begin
            write_data_o   <= axi_write_channel.wdata;
            write_strobe_o <= axi_write_channel.wstrb;
         end
         if (write_state == W_ACCESS) begin
            if (write_done_i) begin
               bresp_q <= write_error_i ? AXI_SLVERR : AXI_OKAY;
            end else if (write_timeout) begin
               bresp_q <= AXI_SLVERR;
            end
         end
      end
   end

   // ---------------- read path ----------------
   assign read_match_o      = axi_read_channel.arvalid &&
                              in_window(axi_read_channel.araddr, LOW_ADDRESS, HIGH_ADDRESS);
   assign ar_ready          = (read_state == R_IDLE) && read_match_o && !read_bus_taken_i;
   assign ar_hs             = ar_ready && axi_read_channel.arvalid;
   assign read_enter_access = ar_hs;

   assign axi_read_channel.arready = ar_ready;
   assign axi_read_channel.rvalid  = (read_state == R_RESPONSE);
   assign axi_read_channel.rdata   = rdata_q;
   assign axi_read_channel.rresp   = rresp_q;
   assign read_request_o           = (read_state == R_ACCESS);
   assign read_busy_o              = (read_state != R_IDLE);

   // Read FSM next-state: address handshake, peripheral access, response.
   always_comb begin
      read_state_next = read_state;
      case (read_state)
         R_IDLE: begin
            if (ar_hs) read_state_next = R_ACCESS;
         end
         R_ACCESS: begin
            if (read_done_i || read_timeout) read_state_next = R_RESPONSE;
         end
         R_RESPONSE: begin
            if (axi_read_channel.rready) read_state_next = R_IDLE;
         end
         default: read_state_next = R_IDLE;
      endcase
   end

   // Read state, captured address and the latched R data/response.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         read_state     <= R_IDLE;
         read_address_o <= '0;
         rdata_q        <= '0;
         rresp_q        <= AXI_OKAY;
      end else begin
         read_state <= read_state_next;
         if (ar_hs) begin
            read_address_o <= axi_read_channel.araddr - LOW_ADDRESS;
         end
         if (read_state == R_ACCESS) begin
            if (read_done_i) begin
               rdata_q <= read_data_i;
               rresp_q <= read_error_i ? AXI_SLVERR : AXI_OKAY;
            end else if (read_timeout) begin
               rdata_q <= '0;
               rresp_q <= AXI_SLVERR;
            end
         end
      end
   end

   // ---------------- optional peripheral timeout ----------------
`ifdef AXI_ENDPOINT_TIMEOUT_EN
   axi_endpoint_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_write_timer (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clear   (write_enter_access),
      .enable  (write_state == W_ACCESS),
      .expired (write_timeout)
   );

   axi_endpoint_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_read_timer (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clear   (read_enter_access),
      .enable  (read_state == R_ACCESS),
      .expired (read_timeout)
   );
`else
   assign write_timeout = 1'b0;
   assign read_timeout  = 1'b0;
`endif

endmodule

// File: doc/axi_slave_endpoint.md
# axi_slave_endpoint

Per-peripheral AXI-Lite endpoint that sits directly downstream of the AXI router on one of its slave ports. It performs the following functions:
- decodes its own address window and drives the router's match inputs;
- completes the AW/W/B and AR/R handshakes;
- converts each transaction into a simple request/done access to the attached peripheral;
- reports busy status back to the router.

Write and read paths are independent state machines.

## Interface
Parameters:
- LOW_ADDRESS, 32'h0000_0000, first byte address of the window (inclusive).
- HIGH_ADDRESS, 32'h0000_0FFF, last byte address of the window (inclusive).
- TIMEOUT_CYCLES, 256, peripheral response limit; used only with AXI_ENDPOINT_TIMEOUT_EN.

Ports:
- clk_i  in  1  single clock; all logic is on the rising edge.
- rst_n_i  in  1  reset, synchronous and active-low.
- axi_write_channel  axi_write_interface.slave  -  AW/W/B channels from the router slave port.
- axi_read_channel  axi_read_interface.slave  -  AR/R channels from the router slave port.
- write_match_o / read_match_o  out  1  AWVALID (ARVALID) and address inside the window; combinational.
- write_busy_o / read_busy_o  out  1  high while the respective FSM is not in IDLE.
- write_bus_taken_i / read_bus_taken_i  in  1  when high, no new AW/W (AR) is accepted.
- write_address_o  out  32  AWADDR − LOW_ADDRESS, registered.
- write_data_o  out  32  captured WDATA.
- write_strobe_o  out  4  captured WSTRB.
- write_request_o  out  1  held high until write_done_i.
- write_done_i  in  1  peripheral completion.
- write_error_i  in  1  valid with write_done_i.
- read_address_o  out  32  ARADDR − LOW_ADDRESS, registered.
- read_request_o  out  1  held high until read_done_i.
- read_data_i  in  32  valid with read_done_i.
- read_done_i  in  1  peripheral completion.
- read_error_i  in  1  valid with read_done_i.

## Operation
Match and window rules:
- Address channels are broadcast to all endpoints, so each endpoint only accepts an address that falls inside its own window.
- Window test: LOW_ADDRESS ≤ addr ≤ HIGH_ADDRESS, unsigned 32-bit.

Write FSM (W_IDLE, W_COLLECT, W_ACCESS, W_RESPONSE):
- AWREADY = (W_IDLE or W_COLLECT) & !aw_captured & write_match_o & !write_bus_taken_i.
- WREADY = (W_IDLE or W_COLLECT) & !w_captured & (aw_captured | (AWVALID & write_match_o)) & !write_bus_taken_i.
  - W is therefore accepted in the same cycle as AW or later, never before.
- W_IDLE → W_COLLECT on any accepted handshake.
- W_IDLE or W_COLLECT → W_ACCESS once both AW and W are captured (possibly in the same cycle).
- W_ACCESS: write_request_o = 1. On write_done_i, latch BRESP = write_error_i ? SLVERR : OKAY and go to W_RESPONSE.
- W_RESPONSE: BVALID = 1 until BREADY, then W_IDLE.

Read FSM (R_IDLE, R_ACCESS, R_RESPONSE):
- ARREADY = R_IDLE & read_match_o & !read_bus_taken_i.
- R_IDLE → R_ACCESS on handshake.
- R_ACCESS: read_request_o = 1. On read_done_i, latch RDATA = read_data_i and RRESP = read_error_i ? SLVERR : OKAY, then go to R_RESPONSE.
- R_RESPONSE: RVALID = 1 until RREADY, then R_IDLE.

Boundary behaviour:
- Simultaneous read and write: fully independent; no arbitration.
- Done asserted in the first ACCESS cycle is legal.
- Done or error outside ACCESS is ignored.
- BREADY/RREADY seen outside RESPONSE is ignored.
- Bus_taken rising after a partial capture (AW without W) does not abort the transaction; the remaining W is accepted once bus_taken falls.

## Timing
- Reset: both FSMs go to IDLE; captured flags cleared.
  - Low after reset: AWREADY, WREADY, ARREADY, BVALID, RVALID, write_request_o, read_request_o, busy outputs.
  - Zero after reset: BRESP, RRESP, RDATA, write_address_o, write_data_o, write_strobe_o, read_address_o.
- Reset asserted mid-transaction drops it silently; the peripheral request deasserts on the next edge.
- Write latency: AW+W handshake at cycle N → write_request_o at N+1 → done at N+k → BVALID at N+k+1.
- Read latency: the same, counted from the AR handshake.
- Back-to-back: a new AW/AR is accepted no earlier than the cycle after B/R completes.

## Configuration
- AXI_ENDPOINT_TIMEOUT_EN defined:
  - a per-FSM counter clears on entry to ACCESS and increments each ACCESS cycle;
  - when it reaches TIMEOUT_CYCLES−1 without done, the request drops and the FSM goes to RESPONSE with SLVERR (RDATA = 0 on reads);
  - done asserted in that same cycle takes priority over the timeout.
- Undefined: no counter is instantiated; ACCESS waits indefinitely.

## Structure
- axi_interface_pkg:
  - axi_response_t (existing);
  - endpoint_write_state_t and endpoint_read_state_t enums;
  - localparam AXI_OKAY / AXI_SLVERR aliases, if not already present.
- One sub-module, axi_endpoint_timer: clear, enable and expired output, parameterised by TIMEOUT_CYCLES; instantiated twice under the macro.

## Test plan
- Aligned write: AW=LOW_ADDRESS+4 and W=32'hDEADBEEF with strobe 4'hF in the same cycle, done at request+0 → write_address_o=4, BVALID two cycles after the handshake, BRESP=OKAY.
- W before AW: WVALID held 3 cycles before AWVALID → WREADY stays low until AWVALID; both handshakes complete in the same cycle.
- Out-of-window AR=HIGH_ADDRESS+1 → read_match_o=0, ARREADY never asserted, read_busy_o stays 0.
- Read with error: read_done_i=1, read_error_i=1, data 32'h1234 → RRESP=SLVERR, RDATA=32'h1234; RVALID held through 4 cycles of RREADY=0.
- Timeout (macro on, TIMEOUT_CYCLES=8): no done → SLVERR after 8 ACCESS cycles, RDATA=0; the same test with the macro off hangs in R_ACCESS.
- rst_n_i low during W_ACCESS → next edge: write_request_o=0, write_busy_o=0, FSM in W_IDLE; a subsequent write completes normally.
